// File: rtl/alu_pkg.sv
// Shared definitions for the stack processor ALU.
//   ALU_WIDTH : default operand/result width
//   oper_t    : 4-bit operation select type
//   OP_*      : the ten defined operation codes; 1010-1111 are reserved
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 16;

    typedef logic [3:0] oper_t;

    localparam oper_t OP_ADD   = 4'b0000;
    localparam oper_t OP_SUB   = 4'b0001;
    localparam oper_t OP_AND   = 4'b0010;
    localparam oper_t OP_OR    = 4'b0011;
    localparam oper_t OP_XOR   = 4'b0100;
    localparam oper_t OP_PASSA = 4'b0101;
    localparam oper_t OP_PASSB = 4'b0110;
    localparam oper_t OP_EQ    = 4'b0111;
    localparam oper_t OP_ZERO  = 4'b1000;
    localparam oper_t OP_BLTA  = 4'b1001;

endpackage

// File: rtl/alu_core.sv
// Combinational operation mux of the stack ALU.
//   oper_i     : operation select
//   a_i        : top-of-stack operand
//   b_i        : next operand
//   result_o   : operation result (unsigned, modulo 2^WIDTH)
//   overflow_o : carry (ADD) or borrow (SUB); 0 for all other codes
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  oper_t            oper_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o,
    output logic             overflow_o
);

    // One extra bit captures the carry out of ADD and the borrow of B-A.
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    assign sum  = {1'b0, a_i} + {1'b0, b_i};
    assign diff = {1'b0, b_i} - {1'b0, a_i};

    always_comb begin
        result_o   = '0;
        overflow_o = 1'b0;
        case (oper_i)
            OP_ADD: begin
                result_o   = sum[WIDTH-1:0];
                overflow_o = sum[WIDTH];
            end
            OP_SUB: begin
                result_o   = diff[WIDTH-1:0];
                overflow_o = diff[WIDTH];
            end
            OP_AND:   result_o = a_i & b_i;
            OP_OR:    result_o = a_i | b_i;
            OP_XOR:   result_o = a_i ^ b_i;
            OP_PASSA: result_o = a_i;
            OP_PASSB: result_o = b_i;
            OP_EQ:    result_o = {{(WIDTH-1){1'b0}}, (a_i == b_i)};
            OP_ZERO:  result_o = {{(WIDTH-1){1'b0}}, (a_i == '0)};
            OP_BLTA:  result_o = {{(WIDTH-1){1'b0}}, (b_i < a_i)};
            default: begin
                result_o   = '0;
                overflow_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/stack_alu.sv
// Stack processor ALU: combinational result plus a registered copy.
//   clk        : system clock, rising edge
//   reset      : asynchronous, active-high; clears the registered outputs
//   Oper       : operation select
//   A, B       : top-of-stack and next operand
//   ALU_Out    : combinational result
//   Overflow   : combinational carry/borrow flag
//   ALU_Out_q  : ALU_Out registered on clk
//   Overflow_q : Overflow registered on clk
module stack_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       Oper,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] ALU_Out,
    output logic             Overflow,
    output logic [WIDTH-1:0] ALU_Out_q,
    output logic             Overflow_q
);

    logic [WIDTH-1:0] result_d;
    logic             overflow_d;
    logic [WIDTH-1:0] result_q;
    logic             overflow_q;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .oper_i     (Oper),
        .a_i        (A),
        .b_i        (B),
        .result_o   (result_d),
        .overflow_o (overflow_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            result_q   <= result_d;
            overflow_q <= overflow_d;
        end
    end

    assign ALU_Out    = result_d;
    assign Overflow   = overflow_d;
    assign ALU_Out_q  = result_q;
    assign Overflow_q = overflow_q;

endmodule

// File: tb/tb_stack_alu.sv
module tb_stack_alu;

    typedef struct {
        string       tag;
        logic [15:0] out;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [3:0]  Oper;
    logic [15:0] A;
    logic [15:0] B;
    logic [15:0] ALU_Out;
    logic        Overflow;
    logic [15:0] ALU_Out_q;
    logic        Overflow_q;

    exp_t sb[$];
    int   vectors;
    int   miscompares;

    stack_alu #(
        .WIDTH (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .Oper       (Oper),
        .A          (A),
        .B          (B),
        .ALU_Out    (ALU_Out),
        .Overflow   (Overflow),
        .ALU_Out_q  (ALU_Out_q),
        .Overflow_q (Overflow_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_val(input string tag, input logic [15:0] o, input logic v);
        exp_t e;
        e.tag = tag;
        e.out = o;
        e.ovf = v;
        sb.push_back(e);
    endtask

    task automatic compare(input logic [15:0] obs_o, input logic obs_v);
        exp_t e;
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty observed=%h/%b required=an entry", obs_o, obs_v);
        end else begin
            e = sb.pop_front();
            vectors++;
            assert (obs_o === e.out) else begin
                miscompares++;
                $error("FAIL %s out observed=%h required=%h", e.tag, obs_o, e.out);
            end
            vectors++;
            assert (obs_v === e.ovf) else begin
                miscompares++;
                $error("FAIL %s ovf observed=%b required=%b", e.tag, obs_v, e.ovf);
            end
        end
    endtask

    task automatic apply_comb(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] eo, input logic ev, input string tag);
        Oper = op;
        A    = a;
        B    = b;
        expect_val(tag, eo, ev);
        #1;
        compare(ALU_Out, Overflow);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset = 1'b1;
        Oper  = 4'b0000;
        A     = 16'h0000;
        B     = 16'h0000;

        // Reset state of the register stage
        expect_val("reset_state", 16'h0000, 1'b0);
        #1;
        compare(ALU_Out_q, Overflow_q);

        // ADD
        apply_comb(4'b0000, 16'h0006, 16'h0009, 16'h000F, 1'b0, "add_basic");
        apply_comb(4'b0000, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, "add_wrap");
        apply_comb(4'b0000, 16'hFFFE, 16'h0001, 16'hFFFF, 1'b0, "add_max");
        // SUB computes B-A
        apply_comb(4'b0001, 16'hBEEF, 16'hDEAD, 16'h1FBE, 1'b0, "sub_basic");
        apply_comb(4'b0001, 16'h1111, 16'h1111, 16'h0000, 1'b0, "sub_equal");
        apply_comb(4'b0001, 16'h0001, 16'h0000, 16'hFFFF, 1'b1, "sub_borrow");
        // Logic and pass
        apply_comb(4'b0010, 16'h2345, 16'hABCD, 16'h2345, 1'b0, "and");
        apply_comb(4'b0011, 16'h2345, 16'hABCD, 16'hABCD, 1'b0, "or");
        apply_comb(4'b0100, 16'h2345, 16'hABCD, 16'h8888, 1'b0, "xor");
        apply_comb(4'b0101, 16'h2345, 16'hABCD, 16'h2345, 1'b0, "passa");
        apply_comb(4'b0110, 16'h2345, 16'hABCD, 16'hABCD, 1'b0, "passb");
        apply_comb(4'b0010, 16'h0000, 16'hFFFF, 16'h0000, 1'b0, "and_edge");
        apply_comb(4'b0011, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b0, "or_edge");
        apply_comb(4'b0100, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b0, "xor_edge");
        // Compares
        apply_comb(4'b0111, 16'hAAAA, 16'hBBBB, 16'h0000, 1'b0, "eq_ne");
        apply_comb(4'b0111, 16'h0ABC, 16'h0ABC, 16'h0001, 1'b0, "eq_eq");
        apply_comb(4'b0111, 16'h0020, 16'h0010, 16'h0000, 1'b0, "eq_ne2");
        apply_comb(4'b1000, 16'hCA11, 16'h0000, 16'h0000, 1'b0, "zero_nz");
        apply_comb(4'b1000, 16'h0000, 16'h1234, 16'h0001, 1'b0, "zero_z");
        apply_comb(4'b1001, 16'hAAAA, 16'hBBBB, 16'h0000, 1'b0, "blta_ge");
        apply_comb(4'b1001, 16'hDEED, 16'hCADE, 16'h0001, 1'b0, "blta_lt");
        apply_comb(4'b1001, 16'hDEAF, 16'hDEAD, 16'h0001, 1'b0, "blta_lt2");
        apply_comb(4'b1001, 16'h5555, 16'h5555, 16'h0000, 1'b0, "blta_eq");
        // Reserved codes
        for (int unsigned k = 10; k < 16; k++) begin
            apply_comb(4'(k), 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, $sformatf("reserved_%0d", k));
        end

        // Register stage: load a nonzero value first
        @(negedge clk);
        reset = 1'b0;
        Oper  = 4'b0000;
        A     = 16'h0006;
        B     = 16'h0009;
        expect_val("reg_load", 16'h000F, 1'b0);
        @(posedge clk);
        #1;
        compare(ALU_Out_q, Overflow_q);

        // Asynchronous clear mid-cycle
        reset = 1'b1;
        expect_val("reg_async_clear", 16'h0000, 1'b0);
        #1;
        compare(ALU_Out_q, Overflow_q);

        // Held at zero across an edge while reset is high
        expect_val("reg_reset_hold", 16'h0000, 1'b0);
        @(posedge clk);
        #1;
        compare(ALU_Out_q, Overflow_q);

        // Release reset, ADD FFFF+0001: unchanged before the edge, loaded after
        @(negedge clk);
        reset = 1'b0;
        Oper  = 4'b0000;
        A     = 16'hFFFF;
        B     = 16'h0001;
        expect_val("reg_before_edge", 16'h0000, 1'b0);
        #1;
        compare(ALU_Out_q, Overflow_q);
        expect_val("reg_after_edge", 16'h0000, 1'b1);
        @(posedge clk);
        #1;
        compare(ALU_Out_q, Overflow_q);

        // One-cycle latency: old value held until the next edge
        @(negedge clk);
        Oper = 4'b0001;
        A    = 16'h0001;
        B    = 16'h0000;
        expect_val("reg_latency_hold", 16'h0000, 1'b1);
        #1;
        compare(ALU_Out_q, Overflow_q);
        expect_val("reg_latency_load", 16'hFFFF, 1'b1);
        @(posedge clk);
        #1;
        compare(ALU_Out_q, Overflow_q);

        if (sb.size() != 0) begin
            miscompares++;
            $error("FAIL scoreboard_leftover observed=%0d required=0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
